// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types for the multicycle control unit.
// Opcode map, FSM states, instruction classes and mux encodings.
package ctrl_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC, MEM, WB, HALT
  } state_t;

  typedef enum logic [3:0] {
    CL_NONE, CL_R, CL_I, CL_LUI, CL_AUIPC,
    CL_LW, CL_SW, CL_BR, CL_JAL, CL_JALR
  } class_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_BR    = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_LUI   = 2'b11;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_LINK = 2'b10;

endpackage

// File: rtl/opcode_classifier.sv
// opcode_classifier: maps the 7-bit opcode to an instruction class.
// Purely combinational; valid is low for opcodes outside RV32I subset.
module opcode_classifier
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output class_t     cls,
  output logic       valid
);

  // Opcode lookup; anything unlisted is reported as not valid.
  always_comb begin
    cls   = CL_NONE;
    valid = 1'b1;
    unique case (opcode)
      OP_R:     cls = CL_R;
      OP_I:     cls = CL_I;
      OP_LUI:   cls = CL_LUI;
      OP_AUIPC: cls = CL_AUIPC;
      OP_LW:    cls = CL_LW;
      OP_SW:    cls = CL_SW;
      OP_BR:    cls = CL_BR;
      OP_JAL:   cls = CL_JAL;
      OP_JALR:  cls = CL_JALR;
      default:  valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: FETCH/DECODE/EXEC/MEM/WB control FSM with
// memory-wait timeout. Macro CTRL_ILLEGAL_TRAP_EN traps undecoded opcodes.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic       branch,
  output logic       alu_src_a,
  output logic       alu_src,
  output logic [1:0] mem_to_reg,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic [1:0] alu_op,
  output logic       fault,
`ifdef CTRL_ILLEGAL_TRAP_EN
  output logic       illegal_instr,
`endif
  output logic [2:0] state_o
);

  localparam int CW = (CNT_W > 0) ? CNT_W : 1;
  localparam logic [CW-1:0] LIM =
    CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t  state, nstate;
  class_t  cls_q, cls_d, cls_dec;
  logic    cls_ok;
  logic [CW-1:0] cnt, cnt_d;
  logic    fault_q, fault_d;
  logic    at_limit;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic    illegal_q, illegal_d;
`endif

  opcode_classifier u_cls (
    .opcode (opcode),
    .cls    (cls_dec),
    .valid  (cls_ok)
  );

  assign at_limit = (TIMEOUT_CYCLES > 0) && (cnt == LIM);

  // State, class, wait counter and sticky flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= FETCH;
      cls_q   <= CL_NONE;
      cnt     <= '0;
      fault_q <= 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state   <= nstate;
      cls_q   <= cls_d;
      cnt     <= cnt_d;
      fault_q <= fault_d;
`ifdef CTRL_ILLEGAL_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  // Next state and control outputs, all forced low during reset.
  always_comb begin
    nstate     = state;
    cls_d      = cls_q;
    cnt_d      = '0;
    fault_d    = fault_q;
`ifdef CTRL_ILLEGAL_TRAP_EN
    illegal_d  = illegal_q;
`endif
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    branch     = 1'b0;
    alu_src_a  = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = WB_ALU;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_op     = ALU_ADD;

    if (state == EXEC || state == MEM || state == WB) begin
      unique case (cls_q)
        CL_R:     alu_op = ALU_FUNCT;
        CL_I: begin
          alu_src = 1'b1;
          alu_op  = ALU_FUNCT;
        end
        CL_LUI: begin
          alu_src = 1'b1;
          alu_op  = ALU_LUI;
        end
        CL_AUIPC: begin
          alu_src_a = 1'b1;
          alu_src   = 1'b1;
        end
        CL_LW, CL_SW: alu_src = 1'b1;
        CL_BR:    alu_op = ALU_BR;
        default: ;
      endcase
    end

    unique case (state)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          nstate   = DECODE;
        end else if (at_limit) begin
          fault_d = 1'b1;
          nstate  = HALT;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      DECODE: begin
        if (cls_ok) begin
          cls_d  = cls_dec;
          nstate = EXEC;
        end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          illegal_d = 1'b1;
          nstate    = HALT;
`else
          nstate    = FETCH;
`endif
        end
      end
      EXEC: begin
        unique case (cls_q)
          CL_LW, CL_SW: nstate = MEM;
          CL_BR: begin
            branch = 1'b1;
            pc_src = 1'b1;
            nstate = FETCH;
          end
          CL_JAL, CL_JALR: begin
            pc_write = 1'b1;
            pc_src   = 1'b1;
            nstate   = WB;
          end
          CL_NONE: nstate = FETCH;
          default: nstate = WB;
        endcase
      end
      MEM: begin
        dmem_req  = 1'b1;
        mem_read  = (cls_q == CL_LW);
        mem_write = (cls_q == CL_SW);
        if (dmem_ready) begin
          nstate = (cls_q == CL_LW) ? WB : FETCH;
        end else if (at_limit) begin
          fault_d = 1'b1;
          nstate  = HALT;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      WB: begin
        reg_write = 1'b1;
        if (cls_q == CL_LW)
          mem_to_reg = WB_MEM;
        else if (cls_q == CL_JAL || cls_q == CL_JALR)
          mem_to_reg = WB_LINK;
        nstate = FETCH;
      end
      HALT:    nstate = HALT;
      default: nstate = FETCH;
    endcase

    if (!reset) begin
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      branch     = 1'b0;
      alu_src_a  = 1'b0;
      alu_src    = 1'b0;
      mem_to_reg = WB_ALU;
      reg_write  = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      alu_op     = ALU_ADD;
    end
  end

  assign state_o = reset ? state : FETCH;
  assign fault   = reset & fault_q;
`ifdef CTRL_ILLEGAL_TRAP_EN
  assign illegal_instr = reset & illegal_q;
`endif

endmodule
